output_logic: RTL
=================

OUTPUT_LOGIC -- requirements
Module: output_logic

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the byte width of the FIFO and output data paths.
REQ-002 Parameter DATA_SIZE, default 6, SHALL set the width of the header size field, header bits [DATA_SIZE-1:0].
REQ-003 Parameter TIMEOUT_CYCLES, default 255, SHALL set the ack-wait limit; it is used only with OUTPUT_LOGIC_TIMEOUT_EN.
REQ-004 Port clk, input, 1: the single clock; all logic SHALL be rising-edge triggered.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port fifo_data_out, input, DATA_WIDTH: channel FIFO head byte, first-word fall-through, valid when fifo_empty=0.
REQ-007 Port fifo_empty, input, 1: the channel FIFO holds no readable byte.
REQ-008 Port fifo_pkt_avail, input, 1: at least one committed packet is in the FIFO.
REQ-009 Port fifo_pop, output, 1: removes the head byte in the same cycle.
REQ-010 Port fifo_rd_ptr_upd, output, 1: one-cycle pulse that releases the space of a finished packet.
REQ-011 Port crc_en, input, 1: the packet carries one trailing CRC byte after the payload.
REQ-012 Port data_out, output, DATA_WIDTH: registered output byte.
REQ-013 Port data_out_req, output, 1: data_out is valid and held.
REQ-014 Port data_out_ack, input, 1: the downstream accepts the byte; it is ignored while data_out_req=0.
REQ-015 Port timeout_err, output, 1: one-cycle pulse when a packet is aborted on timeout.

Function
REQ-016 The FSM SHALL have four states: IDLE, SEND, WAIT and DRAIN.
REQ-017 The internal strobe load_c SHALL be true in any of these cases:
- IDLE and fifo_pkt_avail=1 and fifo_empty=0
- SEND and data_out_ack=1 and cnt!=0 and fifo_empty=0
- WAIT and fifo_empty=0
REQ-018 On load_c the block SHALL assert fifo_pop in the same cycle, register data_out<=fifo_data_out, and drive data_out_req=1 from the next cycle.
REQ-019 A header load from IDLE SHALL set cnt<=fifo_data_out[DATA_SIZE-1:0]+crc_en and move to SEND.
REQ-020 Every later load SHALL decrement cnt by 1.
REQ-021 In SEND with data_out_ack=1 and cnt!=0 and fifo_empty=1, the block SHALL drop data_out_req next cycle and go to WAIT.
REQ-022 In SEND with data_out_ack=1 and cnt==0, the block SHALL:
- drop data_out_req next cycle
- pulse fifo_rd_ptr_upd in that ack cycle
- return to IDLE
REQ-023 A new packet SHALL NOT start in the same cycle as the end-of-packet ack, giving a minimum one-cycle gap.
REQ-024 data_out SHALL stay constant while data_out_req=1 and no ack has been received.
REQ-025 A packet of size 0 with crc_en=0 SHALL be exactly one header byte.
REQ-026 Total bytes per packet SHALL be 1 + size + crc_en.
REQ-027 cnt SHALL be DATA_SIZE+1 bits wide so that size=2^DATA_SIZE-1 plus CRC does not wrap.
REQ-028 crc_en SHALL be sampled only at the header load, and SHALL be held constant by the system for the whole packet.
REQ-029 fifo_pop SHALL never be asserted while fifo_empty=1.
REQ-030 Throughput SHALL be one byte per cycle when data_out_ack is held high and the FIFO is non-empty.

Reset
REQ-031 With rst=1 at a clock edge, the block SHALL set state=IDLE, cnt=0, data_out=0 and data_out_req=0.
REQ-032 During reset, fifo_pop, fifo_rd_ptr_upd and timeout_err SHALL be 0.
REQ-033 Reset mid-packet SHALL abandon the packet without further pops; FIFO recovery belongs to the FIFO reset.

Configuration
REQ-034 Macro OUTPUT_LOGIC_TIMEOUT_EN defined: a wait counter SHALL count consecutive SEND cycles with data_out_req=1 and data_out_ack=0, and clear on ack.
REQ-035 Macro defined, counter reaching TIMEOUT_CYCLES: the block SHALL drop data_out_req, pulse timeout_err and enter DRAIN.
REQ-036 Macro defined, DRAIN state:
- pop one byte per cycle while fifo_empty=0 and cnt!=0, decrementing cnt
- at cnt==0, pulse fifo_rd_ptr_upd and go to IDLE
REQ-037 Macro undefined: there SHALL be no wait counter and DRAIN is unreachable, timeout_err SHALL be tied to 0, and SEND waits indefinitely.

Verification
REQ-038 FIFO holds header 0x03 + bytes A1 A2 A3, crc_en=0, ack held high -> 4 consecutive bytes 0x03 A1 A2 A3, 4 pops, fifo_rd_ptr_upd on the A3 ack cycle.
REQ-039 Header 0x02, crc_en=1, ack asserted every third cycle -> 4 bytes transmitted, data_out stable between acks, req low one cycle after the final ack.
REQ-040 Header 0x00, crc_en=0 -> single header byte, then IDLE, then a back-to-back second packet starts after a one-cycle gap.
REQ-041 Header 0x05, fifo_empty rises after the 2nd payload byte -> WAIT with req=0, resumes on refill, all 6 bytes delivered in order.
REQ-042 rst=1 asserted on the 3rd byte of a 0x04 packet -> next cycle req=0, pop=0, state IDLE, and ack pulses are ignored afterwards.
REQ-043 With OUTPUT_LOGIC_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack never asserted on header 0x03 -> timeout_err pulse after 8 cycles, 3 drain pops, one fifo_rd_ptr_upd; without the macro, req stays high indefinitely.

Source files
------------

// File: rtl/output_logic.sv
// output_logic: streams length-prefixed packets from a first-word fall-through channel FIFO
// onto a registered req/ack byte interface. The header byte carries the payload size in its
// low DATA_SIZE bits, and an optional trailing CRC byte follows the payload when crc_en is set.
// Defining OUTPUT_LOGIC_TIMEOUT_EN adds an ack-wait timeout. A timeout aborts the packet, and
// the DRAIN state then discards the remaining bytes of that packet.
module output_logic #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned DATA_SIZE      = 6,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_pkt_avail,
    output logic                  fifo_pop,
    output logic                  fifo_rd_ptr_upd,
    input  logic                  crc_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_req,
    input  logic                  data_out_ack,
    output logic                  timeout_err
);

    // One extra bit so that a maximum-size header plus a CRC byte cannot wrap.
    localparam int unsigned CntWidth = DATA_SIZE + 1;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait,
        StDrain
    } state_e;

    state_e                state_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  req_q;

    logic                  cnt_zero;
    logic                  acked;
    logic                  hdr_load;
    logic                  load_c;
    logic                  eop_c;
    logic                  timeout_c;
    logic                  drain_pop;
    logic                  drain_done;
    logic [CntWidth-1:0]   hdr_cnt;

    // cnt holds the number of bytes still to be loaded after the one currently presented.
    assign cnt_zero = (cnt_q == '0);
    assign acked    = (state_q == StSend) && req_q && data_out_ack;
    assign hdr_load = (state_q == StIdle) && fifo_pkt_avail && !fifo_empty;
    assign load_c   = hdr_load
                   || (acked && !cnt_zero && !fifo_empty)
                   || ((state_q == StWait) && !fifo_empty);
    assign eop_c    = acked && cnt_zero;
    assign hdr_cnt  = CntWidth'(fifo_data_out[DATA_SIZE-1:0]) + CntWidth'(crc_en);

`ifdef OUTPUT_LOGIC_TIMEOUT_EN
    localparam int unsigned WaitWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WaitWidth-1:0] wait_q;
    logic                 stalled;

    assign stalled    = (state_q == StSend) && req_q && !data_out_ack;
    // Fires on the TIMEOUT_CYCLES-th consecutive unacknowledged cycle.
    assign timeout_c  = stalled && (wait_q == WaitWidth'(TIMEOUT_CYCLES - 1));
    assign drain_pop  = (state_q == StDrain) && !cnt_zero && !fifo_empty;
    assign drain_done = (state_q == StDrain) && cnt_zero;

    // Count consecutive stalled SEND cycles; any ack or leaving SEND restarts the count.
    always_ff @(posedge clk) begin
        if (rst || !stalled || timeout_c) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + WaitWidth'(1);
        end
    end

    assign timeout_err = timeout_c && !rst;
`else
    // The limit only matters when the timeout feature is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);

    assign timeout_c   = 1'b0;
    assign drain_pop   = 1'b0;
    assign drain_done  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Pops and pointer release are combinational strobes, and they are silenced while reset is held.
    assign fifo_pop        = (load_c || drain_pop) && !rst;
    assign fifo_rd_ptr_upd = (eop_c || drain_done) && !rst;

    assign data_out     = data_q;
    assign data_out_req = req_q;

    // Packet sequencing FSM with registered data_out and data_out_req.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            if (load_c) begin
                data_q <= fifo_data_out;
            end
            unique case (state_q)
                StIdle: begin
                    if (hdr_load) begin
                        cnt_q   <= hdr_cnt;
                        req_q   <= 1'b1;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (timeout_c) begin
                        req_q   <= 1'b0;
                        state_q <= StDrain;
                    end else if (acked) begin
                        if (cnt_zero) begin
                            // Last byte accepted. Going through IDLE forces a one-cycle gap.
                            req_q   <= 1'b0;
                            state_q <= StIdle;
                        end else if (fifo_empty) begin
                            req_q   <= 1'b0;
                            state_q <= StWait;
                        end else begin
                            cnt_q <= cnt_q - CntWidth'(1);
                        end
                    end
                end
                StWait: begin
                    if (!fifo_empty) begin
                        cnt_q   <= cnt_q - CntWidth'(1);
                        req_q   <= 1'b1;
                        state_q <= StSend;
                    end
                end
                StDrain: begin
`ifdef OUTPUT_LOGIC_TIMEOUT_EN
                    if (cnt_zero) begin
                        state_q <= StIdle;
                    end else if (!fifo_empty) begin
                        cnt_q <= cnt_q - CntWidth'(1);
                    end
`else
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
